// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU datapath.
//   ALU_WIDTH   : default operand/result width
//   CLA_GROUP   : bits per carry-lookahead group
//   flags_t     : registered adder flags {zero, ovf, cout}
//   FLAGS_RESET : flag values held while in reset (sum == 0, so zero is set)
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned CLA_GROUP = 4;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic cout;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{zero: 1'b1, ovf: 1'b0, cout: 1'b0};

    // Number of lookahead groups needed to cover a given width.
    function automatic int unsigned cla_groups(input int unsigned width);
        return (width + CLA_GROUP - 1) / CLA_GROUP;
    endfunction

endpackage

// File: rtl/alu_adder_if.sv
// Operand/result bundle for alu_adder.
//   master : drives in_valid, a, b, cin; observes the registered results
//   slave  : the adder; consumes operands, drives out_valid, sum, cout, zero, ovf
interface alu_adder_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum, cout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum, cout, zero, ovf
    );

endinterface

// File: rtl/cla4.sv
// 4-bit carry-lookahead group.
//   i_g, i_p  : per-bit generate / propagate
//   i_ci      : carry into the group
//   o_c[4:1]  : carries into bits 1..3 and out of bit 3
//   o_grp_g   : group generate (carry out regardless of i_ci)
//   o_grp_p   : group propagate (carry out follows i_ci)
module cla4 (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_ci,
    output logic [4:1] o_c,
    output logic       o_grp_g,
    output logic       o_grp_p
);

    assign o_c[1] = i_g[0] | (i_p[0] & i_ci);

    assign o_c[2] = i_g[1]
                  | (i_p[1] & i_g[0])
                  | (i_p[1] & i_p[0] & i_ci);

    assign o_c[3] = i_g[2]
                  | (i_p[2] & i_g[1])
                  | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_ci);

    assign o_c[4] = o_grp_g | (o_grp_p & i_ci);

    assign o_grp_g = i_g[3]
                   | (i_p[3] & i_g[2])
                   | (i_p[3] & i_p[2] & i_g[1])
                   | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);

    assign o_grp_p = &i_p;

endmodule

// File: rtl/alu_adder.sv
// Registered WIDTH-bit adder, a + b + cin, with zero and signed-overflow flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_adder_if slave (in_valid/a/b/cin in, out_valid/sum/cout/zero/ovf out)
// One cycle latency, one operation per cycle. Results hold while in_valid is low;
// only out_valid follows in_valid.
module alu_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input logic         clk,
    input logic         rst_n,
    alu_adder_if.slave  bus
);

    localparam int unsigned NumGroups = cla_groups(WIDTH);
    localparam int unsigned PadWidth  = NumGroups * CLA_GROUP;

    logic [PadWidth-1:0] w_g;
    logic [PadWidth-1:0] w_p;
    logic [PadWidth:0]   w_c;
    logic [4:1]          w_grp_c [NumGroups];
    logic [NumGroups-1:0] w_grp_g;
    logic [NumGroups-1:0] w_grp_p;
    // Each group's own c[4] duplicates the G/P ripple below.
    logic [NumGroups-1:0] w_unused_c4;
    logic [WIDTH-1:0]    w_sum;
    flags_t              w_flags;

    logic                r_valid;
    logic [WIDTH-1:0]    r_sum;
    flags_t              r_flags;

    // Bits beyond WIDTH in the last group are tied to g = p = 0, so no carry
    // is created or passed through them.
    for (genvar i = 0; i < PadWidth; i++) begin : g_bit
        if (i < WIDTH) begin : g_live
            assign w_g[i] = bus.a[i] & bus.b[i];
            assign w_p[i] = bus.a[i] ^ bus.b[i];
        end else begin : g_tie
            assign w_g[i] = 1'b0;
            assign w_p[i] = 1'b0;
        end
    end

    assign w_c[0] = bus.cin;

    for (genvar k = 0; k < NumGroups; k++) begin : g_grp
        cla4 u_cla4 (
            .i_g     (w_g[CLA_GROUP*k +: CLA_GROUP]),
            .i_p     (w_p[CLA_GROUP*k +: CLA_GROUP]),
            .i_ci    (w_c[CLA_GROUP*k]),
            .o_c     (w_grp_c[k]),
            .o_grp_g (w_grp_g[k]),
            .o_grp_p (w_grp_p[k])
        );

        assign w_c[CLA_GROUP*k+1 +: CLA_GROUP-1] = w_grp_c[k][3:1];
        // Group carry ripples to the next group through G/P only.
        assign w_c[CLA_GROUP*(k+1)] = w_grp_g[k] | (w_grp_p[k] & w_c[CLA_GROUP*k]);
        assign w_unused_c4[k]       = w_grp_c[k][4];
    end

    if (PadWidth > WIDTH) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^w_c[PadWidth:WIDTH+1];
    end

    assign w_sum = w_p[WIDTH-1:0] ^ w_c[WIDTH-1:0];

    always_comb begin
        w_flags      = FLAGS_RESET;
        w_flags.cout = w_c[WIDTH];
        w_flags.zero = (w_sum == '0);
        w_flags.ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_flags <= FLAGS_RESET;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum   <= w_sum;
                r_flags <= w_flags;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_flags.cout;
    assign bus.zero      = r_flags.zero;
    assign bus.ovf       = r_flags.ovf;

endmodule

// File: tb/tb_alu_adder.sv
// Directed and swept checks for alu_adder at WIDTH = 3 and WIDTH = 32.
// Results are sampled 1 ns after the rising edge that registers them.
module tb_alu_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_adder_if #(.WIDTH(3))  if3  ();
    alu_adder_if #(.WIDTH(32)) if32 ();

    alu_adder #(.WIDTH(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    alu_adder #(.WIDTH(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed 3-bit view: {out_valid, cout, zero, ovf, sum[2:0]}
    function automatic logic [6:0] obs3();
        return {if3.out_valid, if3.cout, if3.zero, if3.ovf, if3.sum};
    endfunction

    // Observed 32-bit view: {out_valid, cout, zero, ovf, sum[31:0]}
    function automatic logic [35:0] obs32();
        return {if32.out_valid, if32.cout, if32.zero, if32.ovf, if32.sum};
    endfunction

    task automatic t3(input string tag, input logic [2:0] a, input logic [2:0] b, input logic cin,
                      input logic [2:0] es, input logic ec, input logic ez, input logic eo);
        @(negedge clk);
        if3.in_valid = 1'b1;
        if3.a        = a;
        if3.b        = b;
        if3.cin      = cin;
        @(posedge clk);
        #1;
        check(tag, 64'(obs3()), 64'({1'b1, ec, ez, eo, es}));
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic cin);
        @(negedge clk);
        if32.in_valid = 1'b1;
        if32.a        = a;
        if32.b        = b;
        if32.cin      = cin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] ref_full;
        logic        ref_ovf;

        if3.in_valid  = 1'b0;
        if3.a         = '0;
        if3.b         = '0;
        if3.cin       = 1'b0;
        if32.in_valid = 1'b0;
        if32.a        = '0;
        if32.b        = '0;
        if32.cin      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset3", 64'(obs3()), 64'(7'b0_0_1_0_000));
        check("reset32", 64'(obs32()), 64'({4'b0010, 32'h0}));

        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back directed vectors, WIDTH = 3
        t3("zero_c0",   3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        t3("zero_c1",   3'b000, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        t3("ones_p_c",  3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
        t3("b_ones",    3'b000, 3'b111, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
        t3("5p2p1",     3'b101, 3'b010, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
        t3("2p7",       3'b010, 3'b111, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
        t3("7p7p1",     3'b111, 3'b111, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
        t3("ovf_pos",   3'b011, 3'b001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1);
        t3("ovf_neg",   3'b100, 3'b100, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1);
        t3("ovf_3p3p1", 3'b011, 3'b011, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1);

        // in_valid low: out_valid drops, results hold from the last vector
        @(negedge clk);
        if3.in_valid = 1'b0;
        if3.a        = 3'b001;
        if3.b        = 3'b001;
        if3.cin      = 1'b0;
        @(posedge clk);
        #1;
        check("hold", 64'(obs3()), 64'(7'b0_0_0_1_111));

        // Asynchronous reset in the middle of a valid cycle
        t3("pre_rst", 3'b001, 3'b001, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 64'(obs3()), 64'(7'b0_0_1_0_000));

        // Operands presented during reset are discarded
        if3.in_valid = 1'b1;
        if3.a        = 3'b110;
        if3.b        = 3'b000;
        @(posedge clk);
        #1;
        check("rst_hold", 64'(obs3()), 64'(7'b0_0_1_0_000));

        @(negedge clk);
        rst_n = 1'b1;
        t3("post_rst", 3'b110, 3'b011, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        if3.in_valid = 1'b0;

        // WIDTH = 32 directed corners
        drive32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        check("w32_wrap", 64'(obs32()), 64'({4'b1110, 32'h0000_0000}));
        drive32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("w32_ovf", 64'(obs32()), 64'({4'b1001, 32'h8000_0000}));
        drive32(32'h1234_5678, 32'h8765_4321, 1'b1);
        check("w32_mix", 64'(obs32()), 64'({4'b1000, 32'h9999_999A}));

        // WIDTH = 32 random sweep against a 33-bit reference
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(1, 0));
            if (i % 16 == 0) ra = 32'hFFFF_FFFF;
            drive32(ra, rb, rc);
            ref_full = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            ref_ovf  = (ra[31] == rb[31]) && (ref_full[31] != ra[31]);
            check("w32_rand", 64'(obs32()),
                  64'({1'b1, ref_full[32], (ref_full[31:0] == 32'h0), ref_ovf, ref_full[31:0]}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_adder.md
# alu_adder

Registered WIDTH-bit binary adder with carry-in and carry-out, used as the arithmetic core of the EX-stage ALU. It computes a + b + cin through a carry-lookahead structure and registers the result with a one-cycle latency. It also produces zero and signed-overflow flags for the ALU flag logic.

## Interface
Parameters:
- WIDTH, default 32, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  registered result valid.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- zero  output  1  registered; 1 when sum == 0.
- ovf  output  1  registered signed overflow: (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).

## Operation
- Full (WIDTH+1)-bit result {cout, sum} = a + b + cin; no saturation, wrap-around modulo 2^WIDTH.
- Carry chain: 4-bit carry-lookahead groups (generate g = a&b, propagate p = a^b), group carries rippled between groups; last group is narrower when WIDTH is not a multiple of 4.
- sum[i] = p[i] ^ c[i]; c[0] = cin; cout = c[WIDTH].
- ovf is computed from the operand and result MSBs; it is meaningful only for signed interpretation and is always driven.
- When in_valid = 0 at a clock edge: out_valid <= 0; sum, cout, zero and ovf hold their previous values.
- X-free: no internal state beyond the output registers.

## Timing
- Latency is exactly 1 cycle: operands sampled at rising edge N appear on the outputs after edge N, valid for cycle N+1.
- Throughput is one operation per cycle. There is no backpressure.
- Reset (rst_n = 0, asynchronous assert): out_valid = 0, sum = 0, cout = 0, zero = 1, ovf = 0, immediately and independent of clk.
- Reset release is synchronous to the next rising edge. The first sample is taken at the first edge with rst_n = 1.
- Reset asserted mid-stream discards the in-flight result. No output pulse is produced.
- The combinational path a/b/cin → register D must close timing at WIDTH = 32 within one cycle.

## Structure
- The shared package alu_pkg holds:
  - ALU_WIDTH (default 32);
  - CLA_GROUP = 4;
  - a flags typedef, a packed struct {zero, ovf, cout}.
- One sub-module is used: cla4, a 4-bit carry-lookahead group.
  - Inputs: g[3:0], p[3:0], ci.
  - Outputs: carries c[4:1], group G/P.
  - It is instantiated ceil(WIDTH/4) times through a generate loop; the top tie-off handles the partial group.
- Output registers and the flag logic live in alu_adder.

## Test plan
All checks use WIDTH = 3 unless noted; each result is checked one cycle after the sample edge with out_valid = 1.
- a=000, b=000, cin=0 → sum=000, cout=0, zero=1, ovf=0. Same operands with cin=1 → sum=001, cout=0, zero=0.
- a=111, b=000, cin=1 → sum=000, cout=1, zero=1. a=000, b=111, cin=0 → sum=111, cout=0, ovf=0.
- a=101, b=010, cin=1 → sum=000, cout=1. a=010, b=111, cin=0 → sum=001, cout=1, ovf=0. a=111, b=111, cin=1 → sum=111, cout=1.
- Signed overflow: a=011, b=001, cin=0 → sum=100, ovf=1, cout=0. a=100, b=100 → sum=000, ovf=1, cout=1, zero=1.
- Control:
  - in_valid = 0 for one cycle: out_valid drops to 0 and sum holds its previous value.
  - Assert rst_n = 0 mid-cycle while out_valid = 1: outputs go to reset values before the next edge.
  - Back-to-back valid operands produce back-to-back results.
- WIDTH = 32 random sweep, 10k vectors including 0xFFFFFFFF + 0 + 1 (→ sum 0, cout 1): compare against a behavioural 33-bit reference sum.
